// File: rtl/flop_rc.sv
// Pipeline register with async active-low reset and synchronous clear (bubble insert).
// Latency: one cycle from d to q; reset assertion takes effect immediately, without a clock edge.
// Backpressure: none; loads every cycle, so a stalling stage needs the enabled variant.
module flop_rc #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage flops: reset beats clear, and clear beats load, so a flush discards d.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (clear) begin
            q <= CLEAR_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_flop_rc.sv
module tb_flop_rc;

    localparam logic [13:0] B_RST = 14'h00AA;
    localparam logic [13:0] B_CLR = 14'h0155;

    logic        clk;
    logic        rst_a, clr_a, rst_b, clr_b, rst_c, clr_c;
    logic [13:0] d_a, d_b, q_a, q_b;
    logic        d_c, q_c;

    int checks;
    int fails;

    // A: ID/EX control instance with default reset/clear values.
    flop_rc #(.WIDTH(14)) u_a (
        .clk(clk), .reset(rst_a), .clear(clr_a), .d(d_a), .q(q_a)
    );

    // B: nonzero reset and clear values, so the two are distinguishable.
    flop_rc #(.WIDTH(14), .RESET_VAL(B_RST), .CLEAR_VAL(B_CLR)) u_b (
        .clk(clk), .reset(rst_b), .clear(clr_b), .d(d_b), .q(q_b)
    );

    // C: single-bit register whose bubble value is 1.
    flop_rc #(.WIDTH(1), .CLEAR_VAL(1'b1)) u_c (
        .clk(clk), .reset(rst_c), .clear(clr_c), .d(d_c), .q(q_c)
    );

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full clock period; returns with clk low, 1 time unit after the falling edge.
    task automatic cycle();
        #4 clk = 1'b1;
        #4 clk = 1'b0;
        #1;
    endtask

    // What a stage holds after a rising edge with reset released.
    function automatic logic [13:0] stage_next(input logic clr, input logic [13:0] dv,
                                               input logic [13:0] cv);
        return clr ? cv : dv;
    endfunction

    logic [13:0] exp_a, exp_b;
    logic        exp_c;
    logic [13:0] pipe_in [4];

    initial begin
        checks = 0;
        fails  = 0;
        clk    = 1'b0;
        rst_a = 1'b1; clr_a = 1'b0; d_a = '0;
        rst_b = 1'b1; clr_b = 1'b0; d_b = '0;
        rst_c = 1'b1; clr_c = 1'b0; d_c = 1'b0;
        #3;

        // Async reset: preload all ones, then reset with clk held low.
        d_a = 14'h3FFF;
        cycle();
        chk("preload", q_a, 14'h3FFF);
        rst_a = 1'b0;
        #1;
        chk("async_reset_no_edge", q_a, 14'h0000);
        d_a = 14'h1234;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("reset_holds_edge%0d", i), q_a, 14'h0000);
        end
        rst_a = 1'b1;
        #1;
        chk("deassert_no_change", q_a, 14'h0000);

        // Basic load, then d changes without an edge.
        d_a = 14'b00001000000000;
        cycle();
        chk("basic_load", q_a, 14'h0200);
        d_a = 14'h0000;
        #2;
        chk("hold_between_edges", q_a, 14'h0200);

        // Clear beats a new d on the same edge.
        clr_a = 1'b1;
        d_a   = 14'h3FFF;
        cycle();
        chk("clear_priority", q_a, 14'h0000);
        clr_a = 1'b0;
        cycle();
        chk("after_clear_load", q_a, 14'h3FFF);

        // Back-to-back pipeline.
        pipe_in = '{14'd1, 14'd2, 14'd3, 14'd4};
        for (int i = 0; i < 4; i++) begin
            d_a = pipe_in[i];
            cycle();
            chk($sformatf("pipe_%0d", i), q_a, pipe_in[i]);
        end

        // Reset loaded mid-cycle loses the loaded value.
        d_a = 14'h2AAA;
        cycle();
        chk("load_before_midreset", q_a, 14'h2AAA);
        #2 rst_a = 1'b0;
        #1;
        chk("midcycle_reset", q_a, 14'h0000);
        rst_a = 1'b1;

        // Reset over clear with nonzero RESET_VAL.
        rst_b = 1'b0;
        clr_b = 1'b1;
        d_b   = 14'h3FFF;
        #1;
        chk("b_reset_over_clear", q_b, B_RST);
        cycle();
        chk("b_reset_over_clear_edge", q_b, B_RST);
        rst_b = 1'b1;
        #1;
        chk("b_deassert_holds", q_b, B_RST);
        cycle();
        chk("b_clear_val", q_b, B_CLR);
        clr_b = 1'b0;
        d_b   = 14'h0F0F;
        cycle();
        chk("b_load", q_b, 14'h0F0F);

        // Width 1 with CLEAR_VAL = 1.
        rst_c = 1'b0;
        #1;
        chk("c_reset", {13'd0, q_c}, 14'd0);
        rst_c = 1'b1;
        d_c   = 1'b0;
        clr_c = 1'b1;
        cycle();
        chk("c_clear_is_one", {13'd0, q_c}, 14'd1);
        clr_c = 1'b0;
        cycle();
        chk("c_load_zero", {13'd0, q_c}, 14'd0);
        d_c = 1'b1;
        cycle();
        chk("c_load_one", {13'd0, q_c}, 14'd1);

        // Randomized run against the rule-level model.
        exp_a = q_a === 14'h2AAA ? 14'h2AAA : 14'h0000;
        // Re-establish a known state for every instance before the random phase.
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        d_a = 14'h0001; d_b = 14'h0002; d_c = 1'b0;
        cycle();
        exp_a = 14'h0001; exp_b = 14'h0002; exp_c = 1'b0;
        for (int n = 0; n < 300; n++) begin
            d_a   = 14'($urandom);
            d_b   = 14'($urandom);
            d_c   = 1'($urandom);
            clr_a = ($urandom_range(3) == 0);
            clr_b = ($urandom_range(3) == 0);
            clr_c = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) begin
                rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
                #1;
                chk("rnd_async_a", q_a, 14'h0000);
                chk("rnd_async_b", q_b, B_RST);
                chk("rnd_async_c", {13'd0, q_c}, 14'd0);
                rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
                #1;
            end
            cycle();
            exp_a = stage_next(clr_a, d_a, 14'h0000);
            exp_b = stage_next(clr_b, d_b, B_CLR);
            exp_c = clr_c ? 1'b1 : d_c;
            chk("rnd_a", q_a, exp_a);
            chk("rnd_b", q_b, exp_b);
            chk("rnd_c", {13'd0, q_c}, {13'd0, exp_c});
            // Inputs wiggling between edges must not reach q.
            d_a   = ~d_a;
            clr_b = ~clr_b;
            d_c   = ~d_c;
            #1;
            chk("rnd_hold_a", q_a, exp_a);
            chk("rnd_hold_b", q_b, exp_b);
            chk("rnd_hold_c", {13'd0, q_c}, {13'd0, exp_c});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
